apb_wait_responder: RTL and testbench

- APB completer (responder) that pairs with the team's APB initiator tasks: word-addressed memory with per-transfer programmable wait states and error signalling.
- Sits on the same PCLK/PRESET domain as the initiator. Samples PWAIT during the SETUP phase to stretch the ACCESS phase.
- Flags PSLVERR on reads of never-written locations and on out-of-range addresses.

---
 rtl/apb_wait_responder_if.sv | 30 +++
 rtl/apb_wait_responder.sv | 145 ++++++++++++++
 tb/tb_apb_wait_responder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_wait_responder_if.sv
// APB bus bundle between an initiator and the wait-state responder.
// Carries the select/enable/address/data handshake plus the per-transfer
// PWAIT count and the PREADY/PRDATA/PSLVERR response.
// Modports:
//   master - drives the request side, observes the response
//   slave  - observes the request side, drives the response
interface apb_wait_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 21
);
  logic [3:0]            PWAIT;
  logic                  PSEL;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    output PWAIT, PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PWAIT, PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_wait_responder.sv
// APB completer with a word-addressed memory, programmable wait states per
// transfer and error responses for unwritten or out-of-range locations.
//
// Ports:
//   PCLK    - clock, rising edge active
//   PRESET  - synchronous active-high reset
//   apb     - slave modport: PWAIT/PSEL/PENABLE/PADDR/PWRITE/PWDATA in,
//             PREADY/PRDATA/PSLVERR out
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transfer; a SETUP cycle (PSEL=1, PENABLE=0) is captured here
// ACCESS | counting down the captured wait count; PREADY while count is 0
module apb_wait_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 21,
  parameter int DEPTH      = 256
) (
  input logic               PCLK,
  input logic               PRESET,
  apb_wait_responder_if.slave apb
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic                  capture;
  logic                  complete;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  ready;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  // When the address space cannot exceed DEPTH, every address is in range
  // and the compare is dropped rather than left as a constant.
  generate
    if (DEPTH >= (1 << ADDR_WIDTH)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_partial_range
      assign in_range = (addr_q < DEPTH[ADDR_WIDTH-1:0]);
    end
  endgenerate

  assign idx = addr_q[IDX_W-1:0];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (capture) begin
      addr_q  <= apb.PADDR;
      wdata_q <= apb.PWDATA;
      write_q <= apb.PWRITE;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      valid_q <= '0;
    end else if (complete && write_q && in_range) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Storage is deliberately not reset; the valid bits gate every read.
  always_ff @(posedge PCLK) begin
    if (!PRESET && complete && write_q && in_range) begin
      mem[idx] <= wdata_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        // PSEL with PENABLE already high has no SETUP and is ignored.
        if (apb.PSEL && !apb.PENABLE) begin
          capture = 1'b1;
          cnt_d   = apb.PWAIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!apb.PSEL) begin
          // Initiator abort: drop the transfer without a response.
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response is decoded purely from registered state.
  always_comb begin
    ready       = (state_q == ACCESS) && (cnt_q == 4'd0);
    apb.PREADY  = ready;
    apb.PRDATA  = '0;
    apb.PSLVERR = 1'b0;
    if (ready) begin
      if (!in_range) begin
        apb.PSLVERR = 1'b1;
      end else if (!write_q) begin
        if (valid_q[idx]) begin
          apb.PRDATA = mem[idx];
        end else begin
          apb.PSLVERR = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_wait_responder.sv
module tb_apb_wait_responder;

  logic PCLK;
  logic PRESET;

  apb_wait_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(21)) bus ();
  apb_wait_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(21)) bus16 ();

  // The small-depth instance sees exactly the same requests.
  assign bus16.PWAIT   = bus.PWAIT;
  assign bus16.PSEL    = bus.PSEL;
  assign bus16.PENABLE = bus.PENABLE;
  assign bus16.PADDR   = bus.PADDR;
  assign bus16.PWRITE  = bus.PWRITE;
  assign bus16.PWDATA  = bus.PWDATA;

  apb_wait_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(21), .DEPTH(256)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .apb    (bus.slave)
  );

  apb_wait_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(21), .DEPTH(16)) dut16 (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .apb    (bus16.slave)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  // Behavioural model: shared storage image plus a valid map per instance
  // (index 0: DEPTH 256, index 1: DEPTH 16).
  logic [20:0] mm [256];
  bit          mv [2][256];

  bit          chk_en = 1'b0;
  logic        exp_ready;
  logic [20:0] exp_rdata [2];
  logic        exp_slverr [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (chk_en) begin
      chk("PREADY",    {31'b0, bus.PREADY},    {31'b0, exp_ready});
      chk("PRDATA",    {11'b0, bus.PRDATA},    {11'b0, exp_rdata[0]});
      chk("PSLVERR",   {31'b0, bus.PSLVERR},   {31'b0, exp_slverr[0]});
      chk("PREADY16",  {31'b0, bus16.PREADY},  {31'b0, exp_ready});
      chk("PRDATA16",  {11'b0, bus16.PRDATA},  {11'b0, exp_rdata[1]});
      chk("PSLVERR16", {31'b0, bus16.PSLVERR}, {31'b0, exp_slverr[1]});
    end
  end

  function automatic int depth_of(input int inst);
    return (inst == 0) ? 256 : 16;
  endfunction

  task automatic exp_quiet();
    exp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_rdata[i]  = '0;
      exp_slverr[i] = 1'b0;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++)
        mv[i][a] = 1'b0;
  endtask

  task automatic exp_complete(input bit wr, input int addr);
    exp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_rdata[i]  = '0;
      exp_slverr[i] = 1'b0;
      if (addr >= depth_of(i))
        exp_slverr[i] = 1'b1;
      else if (!wr) begin
        if (mv[i][addr]) exp_rdata[i] = mm[addr];
        else             exp_slverr[i] = 1'b1;
      end
    end
  endtask

  task automatic model_commit(input bit wr, input int addr, input logic [20:0] data);
    if (wr) begin
      for (int i = 0; i < 2; i++)
        if (addr < depth_of(i)) mv[i][addr] = 1'b1;
      mm[addr] = data;
    end
  endtask

  task automatic do_reset();
    PRESET      = 1'b1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    exp_quiet();
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    model_clear();
  endtask

  // One APB transfer. abort_k / reset_k select an ACCESS cycle (0-based) in
  // which PSEL is dropped or PRESET raised; -1 disables. corrupt changes the
  // request fields from the second ACCESS cycle on.
  task automatic xfer(input bit wr, input int addr, input logic [20:0] data,
                      input int w, input int abort_k, input int reset_k,
                      input bit corrupt,
                      output logic [20:0] rd, output logic se,
                      output logic [20:0] rd16, output logic se16,
                      output int lows, output bit done);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr[7:0];
    bus.PWDATA  = data;
    bus.PWAIT   = w[3:0];
    exp_quiet();
    lows = 0;
    done = 1'b0;
    rd = '0; se = 1'b0; rd16 = '0; se16 = 1'b0;
    @(posedge PCLK);
    #1;
    for (int k = 0; k <= w; k++) begin
      bus.PENABLE = 1'b1;
      if (corrupt && k >= 1) begin
        bus.PADDR  = bus.PADDR + 8'd1;
        bus.PWDATA = '0;
        bus.PWRITE = ~wr;
        bus.PWAIT  = 4'd0;
      end
      if (k == abort_k) bus.PSEL = 1'b0;
      if (k == reset_k) PRESET = 1'b1;
      if (k == w) exp_complete(wr, addr);
      else        exp_quiet();
      @(negedge PCLK);
      if (bus.PREADY === 1'b0) lows++;
      rd   = bus.PRDATA;
      se   = bus.PSLVERR;
      rd16 = bus16.PRDATA;
      se16 = bus16.PSLVERR;
      @(posedge PCLK);
      #1;
      if (k == reset_k) begin
        PRESET = 1'b0;
        model_clear();
        break;
      end
      if (k == abort_k) break;
      if (k == w) begin
        done = 1'b1;
        model_commit(wr, addr, data);
      end
    end
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    exp_quiet();
  endtask

  logic [20:0] rd, rd16;
  logic        se, se16;
  int          lows;
  bit          done;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [20:0] wd [4];
    logic [20:0] rexp [4];
    wd[0] = 21'hAC; wd[1] = 21'hAA; wd[2] = 21'hAB; wd[3] = 21'hAC;
    rexp[0] = 21'hAC; rexp[1] = 21'hAA; rexp[2] = 21'hAB; rexp[3] = 21'hAC;

    PRESET      = 1'b1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    bus.PWAIT   = '0;
    exp_quiet();
    model_clear();
    @(posedge PCLK);
    #1;
    chk_en = 1'b1;
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;

    // Unwritten read, then write/read of the full-scale value.
    xfer(1'b0, 8'h20, '0, 0, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
    chk("unwritten_ready", {31'b0, done}, 32'd1);
    chk("unwritten_slverr", {31'b0, se}, 32'd1);
    chk("unwritten_rdata", {11'b0, rd}, 32'd0);
    xfer(1'b1, 8'h00, 21'h123, 0, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
    xfer(1'b1, 8'h20, 21'h1FFFFF, 0, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
    chk("wr20_slverr", {31'b0, se}, 32'd0);
    chk("wr20_oor16_slverr", {31'b0, se16}, 32'd1);
    xfer(1'b0, 8'h20, '0, 0, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
    chk("rd20_rdata", {11'b0, rd}, 32'h1FFFFF);
    chk("rd20_slverr", {31'b0, se}, 32'd0);
    xfer(1'b0, 8'h00, '0, 0, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
    chk("rd00_16_unchanged", {11'b0, rd16}, 32'h123);

    // Zero-wait back-to-back writes then reads.
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 8'h10 + i, wd[i], 0, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 8'h10 + i, '0, 0, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
      chk("zw_lows", lows, 32'd0);
      chk("zw_rdata", {11'b0, rd}, {11'b0, rexp[i]});
    end

    // Wait-state counts, including the maximum.
    xfer(1'b1, 8'h14, 21'hAD, 3, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
    chk("w3_lows", lows, 32'd3);
    xfer(1'b0, 8'h14, '0, 15, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
    chk("w15_lows", lows, 32'd15);
    chk("w15_done", {31'b0, done}, 32'd1);
    chk("w15_rdata", {11'b0, rd}, 32'hAD);

    // Reset in the second ACCESS cycle.
    xfer(1'b1, 8'h15, 21'hAE, 5, -1, 1, 1'b0, rd, se, rd16, se16, lows, done);
    chk("rst_no_ready", {31'b0, done}, 32'd0);
    chk("rst_lows", lows, 32'd2);
    xfer(1'b0, 8'h15, '0, 0, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
    chk("rst_rd15_slverr", {31'b0, se}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 8'h10 + i, '0, 1, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
      chk("rst_cleared_slverr", {31'b0, se}, 32'd1);
    end

    // Request fields changing during ACCESS.
    xfer(1'b1, 8'h16, 21'hAF, 4, -1, -1, 1'b1, rd, se, rd16, se16, lows, done);
    chk("corrupt_lows", lows, 32'd4);
    xfer(1'b0, 8'h16, '0, 0, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
    chk("corrupt_rd16", {11'b0, rd}, 32'hAF);
    xfer(1'b0, 8'h17, '0, 0, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
    chk("corrupt_rd17_slverr", {31'b0, se}, 32'd1);

    // Abort after one ACCESS cycle.
    xfer(1'b1, 8'h18, 21'h55, 2, 1, -1, 1'b0, rd, se, rd16, se16, lows, done);
    chk("abort_no_ready", {31'b0, done}, 32'd0);
    xfer(1'b0, 8'h18, '0, 0, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
    chk("abort_rd18_slverr", {31'b0, se}, 32'd1);

    // ACCESS without SETUP is ignored.
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b1;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 8'h19;
    bus.PWDATA  = 21'h77;
    bus.PWAIT   = 4'd0;
    exp_quiet();
    repeat (3) @(posedge PCLK);
    #1;
    xfer(1'b0, 8'h19, '0, 0, -1, -1, 1'b0, rd, se, rd16, se16, lows, done);
    chk("nosetup_rd19_slverr", {31'b0, se}, 32'd1);

    repeat (2) @(posedge PCLK);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
